// File: rtl/sap_microsequencer.sv
// SAP-1 variable-length T-state microsequencer: Moore control decode, retired-instruction count, halt flag.
// Optional build macro SINGLE_STEP_EN adds run/step inputs and a WAIT state between instructions.
module sap_microsequencer #(
    parameter int FIXED_LEN = 0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             low_clr,
`ifdef SINGLE_STEP_EN
    input  logic             run,
    input  logic             step,
`endif
    input  logic [3:0]       op_code,
    output logic             inc,
    output logic             pc_out_en,
    output logic             low_ld_mar,
    output logic             low_mem_out_en,
    output logic             low_ld_ir,
    output logic             low_ir_out_en,
    output logic             low_ld_acc,
    output logic             acc_out_en,
    output logic             sub_add,
    output logic             subadd_out_en,
    output logic             low_ld_b_reg,
    output logic             low_ld_out_reg,
    output logic             low_halt,
    output logic [5:0]       t_state,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // 4-bit encoding leaves codes 8..15 unused; they fall into the default recovery branch.
    typedef enum logic [3:0] {
        S_T1   = 4'd0,
        S_T2   = 4'd1,
        S_T3   = 4'd2,
        S_T4   = 4'd3,
        S_T5   = 4'd4,
        S_T6   = 4'd5,
        S_HALT = 4'd6,
        S_WAIT = 4'd7
    } state_t;

    state_t state;
    state_t state_nxt;
    state_t last_state;
    state_t done_target;
    state_t after_instr;
    logic   exec_active;

`ifdef SINGLE_STEP_EN
    logic [2:0] step_sync;
    logic       step_rise;

    always_ff @(negedge clk or negedge low_clr) begin
        if (!low_clr) begin
            step_sync <= 3'b000;
        end else begin
            step_sync <= {step_sync[1:0], step};
        end
    end

    assign step_rise   = step_sync[1] & ~step_sync[2];
    assign after_instr = run ? S_T1 : S_WAIT;
`else
    assign after_instr = S_T1;
`endif

    // Falling-edge state register keeps the Moore outputs stable across the datapath's rising edge.
    always_ff @(negedge clk or negedge low_clr) begin
        if (!low_clr) begin
            state       <= S_T1;
            instr_count <= '0;
        end else begin
            state <= state_nxt;
            if (instr_done && (instr_count != {CNT_W{1'b1}})) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        last_state = S_T3;
        case (op_code)
            OP_LDA:         last_state = S_T5;
            OP_ADD, OP_SUB: last_state = S_T6;
            OP_OUT, OP_HLT: last_state = S_T4;
            default:        last_state = S_T3;
        endcase
        if ((FIXED_LEN != 0) && (op_code != OP_HLT)) begin
            last_state = S_T6;
        end
    end

    assign instr_done  = (state == last_state);
    assign exec_active = (state <= last_state);
    assign done_target = ((state == S_T4) && (op_code == OP_HLT)) ? S_HALT : after_instr;

    always_comb begin
        state_nxt = S_T1;
        case (state)
            S_T1:   state_nxt = S_T2;
            S_T2:   state_nxt = S_T3;
            S_T3:   state_nxt = instr_done ? done_target : S_T4;
            S_T4:   state_nxt = instr_done ? done_target : S_T5;
            S_T5:   state_nxt = instr_done ? done_target : S_T6;
            S_T6:   state_nxt = done_target;
            S_HALT: state_nxt = S_HALT;
`ifdef SINGLE_STEP_EN
            S_WAIT: state_nxt = (run || step_rise) ? S_T1 : S_WAIT;
`else
            S_WAIT: state_nxt = S_T1;
`endif
            default: state_nxt = S_T1;
        endcase
    end

    // Control decode: every line idle unless the current T-state asserts it.
    always_comb begin
        inc            = 1'b0;
        pc_out_en      = 1'b0;
        low_ld_mar     = 1'b1;
        low_mem_out_en = 1'b1;
        low_ld_ir      = 1'b1;
        low_ir_out_en  = 1'b1;
        low_ld_acc     = 1'b1;
        acc_out_en     = 1'b0;
        sub_add        = 1'b0;
        subadd_out_en  = 1'b0;
        low_ld_b_reg   = 1'b1;
        low_ld_out_reg = 1'b1;
        low_halt       = 1'b1;
        t_state        = 6'b000000;
        case (state)
            S_T1: begin
                t_state    = 6'b000001;
                pc_out_en  = 1'b1;
                low_ld_mar = 1'b0;
            end
            S_T2: begin
                t_state = 6'b000010;
                inc     = 1'b1;
            end
            S_T3: begin
                t_state        = 6'b000100;
                low_mem_out_en = 1'b0;
                low_ld_ir      = 1'b0;
            end
            S_T4: begin
                t_state = 6'b001000;
                if (exec_active) begin
                    case (op_code)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            low_ir_out_en = 1'b0;
                            low_ld_mar    = 1'b0;
                        end
                        OP_OUT: begin
                            acc_out_en     = 1'b1;
                            low_ld_out_reg = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            S_T5: begin
                t_state = 6'b010000;
                if (exec_active) begin
                    case (op_code)
                        OP_LDA: begin
                            low_mem_out_en = 1'b0;
                            low_ld_acc     = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            low_mem_out_en = 1'b0;
                            low_ld_b_reg   = 1'b0;
                            sub_add        = (op_code == OP_SUB);
                        end
                        default: ;
                    endcase
                end
            end
            S_T6: begin
                t_state = 6'b100000;
                if (exec_active && ((op_code == OP_ADD) || (op_code == OP_SUB))) begin
                    subadd_out_en = 1'b1;
                    low_ld_acc    = 1'b0;
                    sub_add       = (op_code == OP_SUB);
                end
            end
            S_HALT: low_halt = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sap_microsequencer.sv
// Bench for sap_microsequencer: table-driven decode vectors plus program, reset, saturation sequences.
`timescale 1ns/1ps
module tb_sap_microsequencer;

    logic       clk = 1'b0;
    logic       low_clr;
    logic [3:0] tb_op;
    logic       use_model;
    logic [3:0] op0, op1;
    wire  [12:0] ctl0, ctl1;
    wire  [5:0]  ts0, ts1;
    wire         done0, done1;
    wire  [7:0]  cnt0, cnt1;
`ifdef SINGLE_STEP_EN
    logic run = 1'b1;
    logic step = 1'b0;
`endif

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Control vector bit positions: {inc,pc,mar_n,mem_n,ir_n,irout_n,acc_n,accout,sub,saout,b_n,out_n,halt_n}
    localparam logic [12:0] IDLE   = 13'h07C7;
    localparam logic [12:0] M_INC  = 13'h1000;
    localparam logic [12:0] M_PC   = 13'h0800;
    localparam logic [12:0] M_MAR  = 13'h0400;
    localparam logic [12:0] M_MEM  = 13'h0200;
    localparam logic [12:0] M_IR   = 13'h0100;
    localparam logic [12:0] M_IRO  = 13'h0080;
    localparam logic [12:0] M_ACC  = 13'h0040;
    localparam logic [12:0] M_ACCO = 13'h0020;
    localparam logic [12:0] M_SUB  = 13'h0010;
    localparam logic [12:0] M_SAO  = 13'h0008;
    localparam logic [12:0] M_B    = 13'h0004;
    localparam logic [12:0] M_OUT  = 13'h0002;
    localparam logic [12:0] M_HALT = 13'h0001;
    localparam logic [12:0] F1 = IDLE ^ M_PC ^ M_MAR;
    localparam logic [12:0] F2 = IDLE ^ M_INC;
    localparam logic [12:0] F3 = IDLE ^ M_MEM ^ M_IR;

    // Datapath model driven by each sequencer's control lines
    logic [7:0]  rom [16];
    logic [3:0]  pc [2];
    logic [3:0]  mar [2];
    logic [7:0]  ir [2];
    logic [7:0]  acc [2];
    logic [7:0]  breg [2];
    logic [7:0]  outr [2];
    logic [7:0]  bus [2];
    logic [12:0] ctl [2];

    assign ctl[0] = ctl0;
    assign ctl[1] = ctl1;
    assign op0 = use_model ? ir[0][7:4] : tb_op;
    assign op1 = use_model ? ir[1][7:4] : tb_op;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            bus[k] = 8'h00;
            if (ctl[k][11])  bus[k] = {4'h0, pc[k]};
            if (!ctl[k][9])  bus[k] = rom[mar[k]];
            if (!ctl[k][7])  bus[k] = {4'h0, ir[k][3:0]};
            if (ctl[k][5])   bus[k] = acc[k];
            if (ctl[k][3])   bus[k] = ctl[k][4] ? (acc[k] - breg[k]) : (acc[k] + breg[k]);
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!low_clr) begin
                pc[k] <= 4'h0; mar[k] <= 4'h0; ir[k] <= 8'h00;
                acc[k] <= 8'h00; breg[k] <= 8'h00; outr[k] <= 8'h00;
            end else begin
                if (ctl[k][12]) pc[k]   <= pc[k] + 4'h1;
                if (!ctl[k][10]) mar[k] <= bus[k][3:0];
                if (!ctl[k][8])  ir[k]  <= bus[k];
                if (!ctl[k][6])  acc[k] <= bus[k];
                if (!ctl[k][2])  breg[k] <= bus[k];
                if (!ctl[k][1])  outr[k] <= bus[k];
            end
        end
    end

    sap_microsequencer #(.FIXED_LEN(0), .CNT_W(8)) dut0 (
        .clk(clk), .low_clr(low_clr),
`ifdef SINGLE_STEP_EN
        .run(run), .step(step),
`endif
        .op_code(op0),
        .inc(ctl0[12]), .pc_out_en(ctl0[11]), .low_ld_mar(ctl0[10]), .low_mem_out_en(ctl0[9]),
        .low_ld_ir(ctl0[8]), .low_ir_out_en(ctl0[7]), .low_ld_acc(ctl0[6]), .acc_out_en(ctl0[5]),
        .sub_add(ctl0[4]), .subadd_out_en(ctl0[3]), .low_ld_b_reg(ctl0[2]), .low_ld_out_reg(ctl0[1]),
        .low_halt(ctl0[0]), .t_state(ts0), .instr_done(done0), .instr_count(cnt0)
    );

    sap_microsequencer #(.FIXED_LEN(1), .CNT_W(8)) dut1 (
        .clk(clk), .low_clr(low_clr),
`ifdef SINGLE_STEP_EN
        .run(run), .step(step),
`endif
        .op_code(op1),
        .inc(ctl1[12]), .pc_out_en(ctl1[11]), .low_ld_mar(ctl1[10]), .low_mem_out_en(ctl1[9]),
        .low_ld_ir(ctl1[8]), .low_ir_out_en(ctl1[7]), .low_ld_acc(ctl1[6]), .acc_out_en(ctl1[5]),
        .sub_add(ctl1[4]), .subadd_out_en(ctl1[3]), .low_ld_b_reg(ctl1[2]), .low_ld_out_reg(ctl1[1]),
        .low_halt(ctl1[0]), .t_state(ts1), .instr_done(done1), .instr_count(cnt1)
    );

    typedef struct {
        logic        fx;
        logic [3:0]  op;
        int          adv;
        logic [12:0] ctl;
        logic [5:0]  ts;
        logic        done;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset is released just after a falling edge so the first rising edge lands in T1.
    task automatic do_reset();
        low_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        low_clr = 1'b1;
        tick();
    endtask

    task automatic chk_bus(input int k);
        int n;
        n = int'(ctl[k][11]) + int'(!ctl[k][9]) + int'(!ctl[k][7]) + int'(ctl[k][5]) + int'(ctl[k][3]);
        checks++;
        if (n > 1) begin
            errors++;
            $display("FAIL bus_excl dut%0d drivers=%0d exp<=1", k, n);
        end
    endtask

    int lens0[$];
    int lens1[$];
    int start0, start1;
    int exp_len0[5] = '{5, 6, 6, 4, 4};
    int exp_len1[5] = '{6, 6, 6, 6, 4};

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        rom[0] = 8'h09; rom[1] = 8'h1A; rom[2] = 8'h2B; rom[3] = 8'hE0; rom[4] = 8'hF0;
        rom[9] = 8'h10; rom[10] = 8'h05; rom[11] = 8'h03;

        // {fixed_len dut, op, falling edges after T1, ctl, t_state, instr_done}
        vt.push_back('{1'b0, 4'h0, 0, F1,                   6'h01, 1'b0});
        vt.push_back('{1'b0, 4'h0, 1, F2,                   6'h02, 1'b0});
        vt.push_back('{1'b0, 4'h0, 2, F3,                   6'h04, 1'b0});
        vt.push_back('{1'b0, 4'h0, 3, IDLE ^ M_IRO ^ M_MAR, 6'h08, 1'b0});
        vt.push_back('{1'b0, 4'h0, 4, IDLE ^ M_MEM ^ M_ACC, 6'h10, 1'b1});
        vt.push_back('{1'b0, 4'h0, 5, F1,                   6'h01, 1'b0});
        vt.push_back('{1'b0, 4'h1, 3, IDLE ^ M_IRO ^ M_MAR, 6'h08, 1'b0});
        vt.push_back('{1'b0, 4'h1, 4, IDLE ^ M_MEM ^ M_B,   6'h10, 1'b0});
        vt.push_back('{1'b0, 4'h1, 5, IDLE ^ M_SAO ^ M_ACC, 6'h20, 1'b1});
        vt.push_back('{1'b0, 4'h1, 6, F1,                   6'h01, 1'b0});
        vt.push_back('{1'b0, 4'h2, 4, IDLE ^ M_MEM ^ M_B ^ M_SUB,   6'h10, 1'b0});
        vt.push_back('{1'b0, 4'h2, 5, IDLE ^ M_SAO ^ M_ACC ^ M_SUB, 6'h20, 1'b1});
        vt.push_back('{1'b0, 4'hE, 3, IDLE ^ M_ACCO ^ M_OUT, 6'h08, 1'b1});
        vt.push_back('{1'b0, 4'hE, 4, F1,                   6'h01, 1'b0});
        vt.push_back('{1'b0, 4'hF, 3, IDLE,                 6'h08, 1'b1});
        vt.push_back('{1'b0, 4'hF, 4, IDLE ^ M_HALT,        6'h00, 1'b0});
        vt.push_back('{1'b0, 4'hF, 9, IDLE ^ M_HALT,        6'h00, 1'b0});
        vt.push_back('{1'b0, 4'h7, 2, F3,                   6'h04, 1'b1});
        vt.push_back('{1'b0, 4'h7, 3, F1,                   6'h01, 1'b0});
        vt.push_back('{1'b0, 4'h3, 3, F1,                   6'h01, 1'b0});
        vt.push_back('{1'b1, 4'h0, 4, IDLE ^ M_MEM ^ M_ACC, 6'h10, 1'b0});
        vt.push_back('{1'b1, 4'h0, 5, IDLE,                 6'h20, 1'b1});
        vt.push_back('{1'b1, 4'h7, 3, IDLE,                 6'h08, 1'b0});
        vt.push_back('{1'b1, 4'hE, 5, IDLE,                 6'h20, 1'b1});
        vt.push_back('{1'b1, 4'hF, 4, IDLE ^ M_HALT,        6'h00, 1'b0});

        use_model = 1'b0;
        tb_op     = 4'h7;
        low_clr   = 1'b1;
        #2;
        low_clr = 1'b0;
        #1;
        chk("rst_ctl", 32'(ctl0), 32'(F1));
        chk("rst_ts", 32'(ts0), 32'h01);
        chk("rst_cnt", 32'(cnt0), 32'h0);
        chk("rst_ctl_fixed", 32'(ctl1), 32'(F1));

        foreach (vt[i]) begin
            tb_op = vt[i].op;
            do_reset();
            repeat (vt[i].adv) tick();
            if (vt[i].fx) begin
                chk($sformatf("vec%0d_ctl", i), 32'(ctl1), 32'(vt[i].ctl));
                chk($sformatf("vec%0d_ts", i), 32'(ts1), 32'(vt[i].ts));
                chk($sformatf("vec%0d_done", i), 32'(done1), 32'(vt[i].done));
            end else begin
                chk($sformatf("vec%0d_ctl", i), 32'(ctl0), 32'(vt[i].ctl));
                chk($sformatf("vec%0d_ts", i), 32'(ts0), 32'(vt[i].ts));
                chk($sformatf("vec%0d_done", i), 32'(done0), 32'(vt[i].done));
            end
        end

        // Asynchronous clear in the middle of ADD T5
        tb_op = 4'h1;
        do_reset();
        repeat (6) tick();
        chk("add_cnt1", 32'(cnt0), 32'h1);
        repeat (4) tick();
        chk("add_t5", 32'(ts0), 32'h10);
        #1;
        low_clr = 1'b0;
        #1;
        chk("midrst_ctl", 32'(ctl0), 32'(F1));
        chk("midrst_ts", 32'(ts0), 32'h01);
        chk("midrst_cnt", 32'(cnt0), 32'h0);
        chk("midrst_done", 32'(done0), 32'h0);

        // Program LDA 9; ADD A; SUB B; OUT; HLT on both variants
        use_model = 1'b1;
        do_reset();
        start0 = 0;
        start1 = 0;
        for (int n = 0; n < 60; n++) begin
            chk_bus(0);
            chk_bus(1);
            if (done0) begin lens0.push_back(n - start0 + 1); start0 = n + 1; end
            if (done1) begin lens1.push_back(n - start1 + 1); start1 = n + 1; end
            tick();
        end
        chk("prog_ninstr", 32'(lens0.size()), 32'd5);
        chk("prog_ninstr_fixed", 32'(lens1.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < lens0.size()) chk($sformatf("len%0d", i), 32'(lens0[i]), 32'(exp_len0[i]));
            if (i < lens1.size()) chk($sformatf("len_fixed%0d", i), 32'(lens1[i]), 32'(exp_len1[i]));
        end
        chk("prog_out", 32'(outr[0]), 32'h12);
        chk("prog_out_fixed", 32'(outr[1]), 32'h12);
        chk("prog_cnt", 32'(cnt0), 32'd5);
        chk("prog_cnt_fixed", 32'(cnt1), 32'd5);
        chk("prog_halt", 32'(ctl0[0]), 32'h0);
        chk("prog_halt_fixed", 32'(ctl1[0]), 32'h0);
        chk("prog_halt_ts", 32'(ts0), 32'h0);

        // Counter saturation under a long NOP run
        use_model = 1'b0;
        tb_op = 4'h7;
        do_reset();
        repeat (3 * 254) tick();
        chk("nop_cnt254", 32'(cnt0), 32'd254);
        chk("nop_t1", 32'(ts0), 32'h01);
        repeat (3 * 46) tick();
        chk("nop_sat", 32'(cnt0), 32'hFF);

`ifdef SINGLE_STEP_EN
        begin
            int waited;
            run = 1'b0;
            tb_op = 4'h7;
            do_reset();
            repeat (3) tick();
            chk("ss_wait_ts", 32'(ts0), 32'h0);
            chk("ss_wait_ctl", 32'(ctl0), 32'(IDLE));
            repeat (5) tick();
            chk("ss_park", 32'(ts0), 32'h0);
            step = 1'b1;
            waited = 0;
            while ((ts0 != 6'h01) && (waited < 10)) begin
                tick();
                waited++;
            end
            chk("ss_step_t1", 32'(ts0), 32'h01);
            repeat (3) tick();
            step = 1'b0;
            chk("ss_wait2", 32'(ts0), 32'h0);
            chk("ss_cnt", 32'(cnt0), 32'd2);
            run = 1'b1;
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
